fsmc_bus_slave: RTL and testbench

FSMC_BUS_SLAVE -- requirements
Module: fsmc_bus_slave

---
 rtl/fsmc_pkg.sv | 22 ++
 rtl/fsmc_bus_slave_sync_chain.sv | 25 ++
 rtl/fsmc_bus_slave.sv | 156 +++++++++++++++
 tb/tb_fsmc_bus_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// Shared constants for the FSMC bus slave: default parameters and one-hot state encoding.
package fsmc_pkg;

  localparam int ADRW_DEF        = 8;
  localparam int DATW_DEF        = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int RD_TIMEOUT_DEF  = 15;

  localparam int IDLE_IDX     = 0;
  localparam int WRITE_IDX    = 1;
  localparam int RD_WAIT_IDX  = 2;
  localparam int RD_DRIVE_IDX = 3;
  localparam int NUM_STATES   = 4;

  typedef enum logic [NUM_STATES-1:0] {
    IDLE     = 4'(1 << IDLE_IDX),
    WRITE    = 4'(1 << WRITE_IDX),
    RD_WAIT  = 4'(1 << RD_WAIT_IDX),
    RD_DRIVE = 4'(1 << RD_DRIVE_IDX)
  } state_e;

endpackage

// File: rtl/fsmc_bus_slave_sync_chain.sv
// Multi-flop synchroniser whose flops reset to all-ones so that active-low strobes read as idle.
module sync_chain #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '1;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fsmc_bus_slave.sv
// FSMC asynchronous-bus slave: synchronises the strobes, latches address/data, and
// turns bus cycles into single-cycle register read/write requests.
module fsmc_bus_slave
  import fsmc_pkg::*;
#(
  parameter int ADRW        = ADRW_DEF,
  parameter int DATW        = DATW_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int RD_TIMEOUT  = RD_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                aNE,
  input  logic                aNOE,
  input  logic                aNWE,
  input  logic [DATW/8-1:0]   aNBL,
  input  logic [ADRW-1:0]     aAn,
  input  logic [DATW-1:0]     aDn,
  output logic                aNWAIT,
  output logic [ADRW-1:0]     r_adr,
  output logic                do_read,
  input  logic [DATW-1:0]     read_data,
  input  logic                read_valid,
  output logic [ADRW-1:0]     w_adr,
  output logic                do_write,
  output logic [DATW-1:0]     w_data,
  output logic [DATW/8-1:0]   w_be,
  output logic                io_output,
  output logic [DATW-1:0]     io_data,
  output logic                rd_timeout
);

  localparam int NB = DATW / 8;
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  logic          sNE, sNOE, sNWE;
  logic [NB-1:0] sNBL;

  sync_chain #(
    .W      (3 + NB),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  ({aNE, aNOE, aNWE, aNBL}),
    .q_o  ({sNE, sNOE, sNWE, sNBL})
  );

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADRW-1:0]   r_adr_q, r_adr_d, w_adr_q, w_adr_d;
  logic [DATW-1:0]   w_data_q, w_data_d, io_data_q, io_data_d;
  logic [NB-1:0]     w_be_q, w_be_d;
  logic              do_write_q, do_write_d, do_read_q, do_read_d;
  logic              rd_timeout_q, rd_timeout_d;
  logic              armed_q, armed_d;
  logic [SYNC_STAGES-1:0] fill_q;

  // fill_q marks when the synchroniser holds post-reset samples; only then can sNE arm the slave,
  // so a bus cycle already low across reset is ignored until the master deasserts aNE.
  assign armed_d = armed_q | (fill_q[SYNC_STAGES-1] & sNE);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      r_adr_q      <= '0;
      w_adr_q      <= '0;
      w_data_q     <= '0;
      w_be_q       <= '0;
      io_data_q    <= '0;
      do_write_q   <= 1'b0;
      do_read_q    <= 1'b0;
      rd_timeout_q <= 1'b0;
      armed_q      <= 1'b0;
      fill_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      r_adr_q      <= r_adr_d;
      w_adr_q      <= w_adr_d;
      w_data_q     <= w_data_d;
      w_be_q       <= w_be_d;
      io_data_q    <= io_data_d;
      do_write_q   <= do_write_d;
      do_read_q    <= do_read_d;
      rd_timeout_q <= rd_timeout_d;
      armed_q      <= armed_d;
      fill_q       <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    r_adr_d      = r_adr_q;
    w_adr_d      = w_adr_q;
    w_data_d     = w_data_q;
    w_be_d       = w_be_q;
    io_data_d    = io_data_q;
    do_write_d   = 1'b0;
    do_read_d    = 1'b0;
    rd_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (armed_q && !sNE && !sNWE) begin
          w_adr_d    = aAn;
          w_data_d   = aDn;
          w_be_d     = ~sNBL;
          do_write_d = 1'b1;
          state_d    = WRITE;
        end else if (armed_q && !sNE && !sNOE) begin
          r_adr_d   = aAn;
          do_read_d = 1'b1;
          cnt_d     = '0;
          state_d   = RD_WAIT;
        end
      end
      WRITE: begin
        if (sNE || sNWE) state_d = IDLE;
      end
      RD_WAIT: begin
        // Master abort outranks both data arrival and timeout.
        if (sNE || sNOE) begin
          state_d = IDLE;
        end else if (read_valid) begin
          io_data_d = read_data;
          state_d   = RD_DRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(RD_TIMEOUT)) begin
            io_data_d    = '1;
            rd_timeout_d = 1'b1;
            state_d      = RD_DRIVE;
          end
        end
      end
      RD_DRIVE: begin
        if (sNE || sNOE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign aNWAIT     = ~state_q[RD_WAIT_IDX];
  assign io_output  = state_q[RD_DRIVE_IDX] & ~sNE & ~sNOE;
  assign r_adr      = r_adr_q;
  assign w_adr      = w_adr_q;
  assign w_data     = w_data_q;
  assign w_be       = w_be_q;
  assign io_data    = io_data_q;
  assign do_write   = do_write_q;
  assign do_read    = do_read_q;
  assign rd_timeout = rd_timeout_q;

endmodule

// File: tb/tb_fsmc_bus_slave.sv
// Directed scoreboard bench: stimulus queues expected bus events, a negedge monitor
// pops and compares them whenever the slave pulses a request or starts driving the pad.
module tb_fsmc_bus_slave;

  localparam int ADRW = 8;
  localparam int DATW = 16;
  localparam int NB   = 2;
  localparam int SS   = 2;
  localparam int RTO  = 15;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_TO  = 2;
  localparam int K_DRV = 3;

  typedef struct {
    int              kind;
    logic [ADRW-1:0] adr;
    logic [DATW-1:0] data;
    logic [NB-1:0]   be;
  } expEvent_t;

  logic            clk = 1'b0;
  logic            nrst;
  logic            aNE, aNOE, aNWE;
  logic [NB-1:0]   aNBL;
  logic [ADRW-1:0] aAn;
  logic [DATW-1:0] aDn;
  logic            aNWAIT;
  logic [ADRW-1:0] r_adr, w_adr;
  logic            do_read, do_write;
  logic [DATW-1:0] read_data, w_data, io_data;
  logic            read_valid;
  logic [NB-1:0]   w_be;
  logic            io_output, rd_timeout;

  expEvent_t expQ[$];
  int tests  = 0;
  int errors = 0;

  fsmc_bus_slave #(
    .ADRW(ADRW), .DATW(DATW), .SYNC_STAGES(SS), .RD_TIMEOUT(RTO)
  ) dut (
    .clk(clk), .nrst(nrst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE), .aNBL(aNBL),
    .aAn(aAn), .aDn(aDn), .aNWAIT(aNWAIT), .r_adr(r_adr), .do_read(do_read),
    .read_data(read_data), .read_valid(read_valid), .w_adr(w_adr), .do_write(do_write),
    .w_data(w_data), .w_be(w_be), .io_output(io_output), .io_data(io_data),
    .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int kind, input logic [ADRW-1:0] adr,
                         input logic [DATW-1:0] data, input logic [NB-1:0] be);
    expEvent_t e;
    e.kind = kind; e.adr = adr; e.data = data; e.be = be;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(input int kind);
    expEvent_t e;
    if (expQ.size() == 0) begin
      tests++;
      errors++;
      $display("[TB] FAIL unexpected event: got kind %0d, expected none", kind);
      return;
    end
    e = expQ.pop_front();
    checkOutput("event kind", 32'(kind), 32'(e.kind));
    case (kind)
      K_WR: begin
        checkOutput("w_adr", 32'(w_adr), 32'(e.adr));
        checkOutput("w_data", 32'(w_data), 32'(e.data));
        checkOutput("w_be", 32'(w_be), 32'(e.be));
      end
      K_RD:  checkOutput("r_adr", 32'(r_adr), 32'(e.adr));
      K_DRV: checkOutput("io_data", 32'(io_data), 32'(e.data));
      default: ;
    endcase
  endtask

  // Monitor: each output pulse or pad-drive start consumes one scoreboard entry, in a fixed order.
  initial begin
    logic prevIo;
    prevIo = 1'b0;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1) begin
        if (do_write)   scoreEvent(K_WR);
        if (do_read)    scoreEvent(K_RD);
        if (rd_timeout) scoreEvent(K_TO);
        if (io_output && !prevIo) scoreEvent(K_DRV);
      end
      prevIo = io_output;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ne, input logic noe, input logic nwe,
                               input logic [NB-1:0] nbl, input logic [ADRW-1:0] adr,
                               input logic [DATW-1:0] dat);
    @(negedge clk);
    aNE = ne; aNOE = noe; aNWE = nwe; aNBL = nbl; aAn = adr; aDn = dat;
  endtask

  task automatic busIdle(input int cycles);
    applyStimulus(1'b1, 1'b1, 1'b1, '1, aAn, aDn);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitDoRead(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (do_read) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("do_read within budget", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    int n;
    int ioHigh, toHigh;
    nrst = 1'b0; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aNBL = '1;
    aAn = '0; aDn = '0; read_data = '0; read_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset aNWAIT", 32'(aNWAIT), 32'd1);
    checkOutput("reset do_write", 32'(do_write), 32'd0);
    checkOutput("reset do_read", 32'(do_read), 32'd0);
    checkOutput("reset rd_timeout", 32'(rd_timeout), 32'd0);
    checkOutput("reset io_output", 32'(io_output), 32'd0);
    checkOutput("reset r_adr", 32'(r_adr), 32'd0);
    checkOutput("reset w_adr", 32'(w_adr), 32'd0);
    checkOutput("reset w_data", 32'(w_data), 32'd0);
    checkOutput("reset w_be", 32'(w_be), 32'd0);
    checkOutput("reset io_data", 32'(io_data), 32'd0);
    nrst = 1'b1;
    repeat (5) @(negedge clk);

    // Plain write: byte lane 0 only.
    pushExp(K_WR, 8'h03, 16'h1234, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 8'h03, 16'h1234);
    repeat (8) @(negedge clk);
    busIdle(6);
    checkOutput("w_adr held", 32'(w_adr), 32'h03);

    // Read answered three cycles after do_read.
    pushExp(K_RD, 8'h10, '0, '0);
    pushExp(K_DRV, '0, 16'hBEEF, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1, 8'h10, 16'h0000);
    waitDoRead(seen);
    repeat (3) @(negedge clk);
    checkOutput("aNWAIT low before data", 32'(aNWAIT), 32'd0);
    read_valid = 1'b1; read_data = 16'hBEEF;
    @(negedge clk);
    read_valid = 1'b0; read_data = 16'h0000;
    checkOutput("aNWAIT high after data", 32'(aNWAIT), 32'd1);
    checkOutput("io_output driving", 32'(io_output), 32'd1);
    repeat (4) @(negedge clk);
    checkOutput("io_output held", 32'(io_output), 32'd1);
    aNOE = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!io_output) begin
        n = i;
        break;
      end
    end
    checkOutput("io_output release latency", 32'(n), 32'(SS));
    busIdle(4);

    // Stray read_valid while idle must not disturb io_data.
    read_valid = 1'b1; read_data = 16'h1111;
    repeat (3) @(negedge clk);
    read_valid = 1'b0;
    checkOutput("io_data ignores idle read_valid", 32'(io_data), 32'hBEEF);

    // Read that never gets data times out after RTO wait cycles.
    pushExp(K_RD, 8'h20, '0, '0);
    pushExp(K_TO, '0, '0, '0);
    pushExp(K_DRV, '0, 16'hFFFF, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1, 8'h20, 16'h0000);
    waitDoRead(seen);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (aNWAIT) break;
      n++;
    end
    checkOutput("timeout wait cycles", 32'(n), 32'(RTO));
    busIdle(6);

    // Master abort in RD_WAIT: no drive, no timeout.
    pushExp(K_RD, 8'h30, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1, 8'h30, 16'h0000);
    waitDoRead(seen);
    repeat (2) @(negedge clk);
    aNOE = 1'b1;
    ioHigh = 0; toHigh = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (io_output) ioHigh++;
      if (rd_timeout) toHigh++;
    end
    checkOutput("abort io_output cycles", 32'(ioHigh), 32'd0);
    checkOutput("abort rd_timeout pulses", 32'(toHigh), 32'd0);
    checkOutput("abort aNWAIT", 32'(aNWAIT), 32'd1);
    busIdle(4);

    // Both strobes low together: write wins, no read.
    pushExp(K_WR, 8'h40, 16'h5A5A, 2'b11);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 8'h40, 16'h5A5A);
    repeat (6) @(negedge clk);
    busIdle(6);

    // Reset mid-write with strobes still low: nothing until strobes cycle high then low.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 8'h50, 16'h7777);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("w_adr after reset", 32'(w_adr), 32'h00);
    busIdle(5);
    pushExp(K_WR, 8'h51, 16'h00C3, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 8'h51, 16'h00C3);
    repeat (6) @(negedge clk);
    busIdle(6);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
